// File: rtl/app_cmd_serializer.sv
// app_cmd_serializer
//   Transmit end of the app command link. Accepts a parallel device-select word
//   with a valid/ready handshake. It serializes the word onto a single line as
//   follows: a start bit (0), DATA_W data bits sent LSB first, an even parity
//   bit, and a stop bit (1). Each bit lasts BIT_PERIOD clock cycles. The block
//   buffers one frame only and has no queue.
//
//   State table
//     IDLE   | line at 1, ready to accept a command
//     START  | start bit (0) on the line
//     DATA   | data bit shift_reg[0] on the line, repeated DATA_W times
//     PARITY | even parity of the accepted word on the line
//     STOP   | stop bit (1); frame_done pulses as this state is left
//
// Ports
//   clk         in   clock, all state updates on rising edge
//   rst         in   asynchronous active-high reset
//   cmd_data    in   [DATA_W-1:0] device-select word (device_1 = bit 0)
//   cmd_valid   in   cmd_data valid this cycle
//   cmd_ready   out  high while IDLE
//   app_signal  out  serial line, registered, idle level 1
//   busy        out  high while a frame is in progress
//   frame_done  out  registered one-cycle pulse when the stop bit completes
module app_cmd_serializer #(
  parameter int DATA_W     = 4,
  parameter int BIT_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              app_signal,
  output logic              busy,
  output logic              frame_done
);

  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              parity;
  logic [PW-1:0]     period_cnt;
  logic [BW-1:0]     bit_cnt;

  // The next data bit is taken from the shifted value, so the line level and
  // the shift register advance on the same edge.
  assign shift_next = shift_reg >> 1;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity     <= 1'b0;
      period_cnt <= '0;
      bit_cnt    <= '0;
      app_signal <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        app_signal <= 1'b1;
        if (cmd_valid) begin
          shift_reg  <= cmd_data;
          parity     <= ^cmd_data;
          period_cnt <= '0;
          bit_cnt    <= '0;
          state      <= START;
          app_signal <= 1'b0;
        end
      end else if (period_cnt != PERIOD_LAST) begin
        period_cnt <= period_cnt + 1'b1;
      end else begin
        period_cnt <= '0;
        unique case (state)
          START: begin
            state      <= DATA;
            bit_cnt    <= '0;
            app_signal <= shift_reg[0];
          end
          DATA: begin
            if (bit_cnt == BIT_LAST) begin
              state      <= PARITY;
              app_signal <= parity;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              shift_reg  <= shift_next;
              app_signal <= shift_next[0];
            end
          end
          PARITY: begin
            state      <= STOP;
            app_signal <= 1'b1;
          end
          STOP: begin
            state      <= IDLE;
            app_signal <= 1'b1;
            frame_done <= 1'b1;
          end
          default: begin
            state      <= IDLE;
            app_signal <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_app_cmd_serializer.sv
// tb_app_cmd_serializer
//   Drives directed and random commands into app_cmd_serializer. It compares
//   the line, busy, cmd_ready and frame_done outputs on every cycle against a
//   frame-level model. The model keeps the accept cycle and the frame as an
//   array of bits, and it indexes that array by elapsed cycles / BIT_PERIOD.
module tb_app_cmd_serializer;
  localparam int DW    = 4;
  localparam int BP    = 4;
  localparam int TOTAL = (DW + 3) * BP;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cmd_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          app_signal;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  int            cyc = 0;
  bit            m_active = 0;
  int            m_start = 0;
  logic [DW+2:0] m_frame = '0;
  logic          exp_line = 1'b1;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;

  always #5 clk = ~clk;

  app_cmd_serializer #(.DATA_W(DW), .BIT_PERIOD(BP)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .app_signal (app_signal),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".line"},  app_signal, exp_line);
    check({tag, ".busy"},  busy,       exp_busy);
    check({tag, ".ready"}, cmd_ready,  !exp_busy);
    check({tag, ".done"},  frame_done, exp_done);
  endtask

  // Model of one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    cyc++;
    exp_done = 1'b0;
    if (rst) begin
      m_active = 0;
    end else if (m_active && (cyc - m_start) == TOTAL) begin
      m_active = 0;
      exp_done = 1'b1;
    end else if (!m_active && cmd_valid) begin
      m_active = 1;
      m_start  = cyc;
      m_frame  = {1'b1, ^cmd_data, cmd_data, 1'b0};
    end
    exp_busy = m_active;
    exp_line = m_active ? m_frame[(cyc - m_start) / BP] : 1'b1;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic send_once(input logic [DW-1:0] d, input int cycles, input string tag);
    cmd_data  = d;
    cmd_valid = 1'b1;
    step(tag);
    cmd_valid = 1'b0;
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    #1;
    check_all("reset");
    step("reset_hold");
    step("reset_hold");
    rst = 1'b0;

    // Single frames: 0101, parity-one 0111, all-zero 0000.
    send_once(4'b0101, TOTAL + 2, "frame_0101");
    send_once(4'b0111, TOTAL + 2, "frame_0111");
    send_once(4'b0000, TOTAL + 2, "frame_0000");

    // A command offered while busy is not stored; it is sent only if still valid at IDLE.
    cmd_data  = 4'b0001;
    cmd_valid = 1'b1;
    step("busy_drop");
    cmd_data  = 4'b1000;
    for (int i = 0; i < 10; i++) step("busy_drop");
    cmd_valid = 1'b0;
    for (int i = 0; i < TOTAL + 4; i++) step("busy_drop");
    cmd_data  = 4'b0001;
    cmd_valid = 1'b1;
    step("busy_late");
    cmd_data  = 4'b1000;
    for (int i = 0; i < TOTAL + 2; i++) step("busy_late");
    cmd_valid = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) step("busy_late");

    // Back-to-back frames with cmd_valid held high.
    cmd_data  = 4'b0010;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3 * (TOTAL + 1) + 2; i++) step("b2b");
    cmd_valid = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) step("b2b_tail");

    // cmd_data changing after acceptance must not affect the frame.
    cmd_data  = 4'b0100;
    cmd_valid = 1'b1;
    step("data_hold");
    cmd_valid = 1'b0;
    cmd_data  = 4'b1111;
    for (int i = 0; i < TOTAL + 2; i++) step("data_hold");

    // Asynchronous reset in the middle of DATA, with a command offered during reset.
    send_once(4'b1011, 8, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    m_active = 0;
    exp_line = 1'b1;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    check_all("async_reset");
    cmd_data  = 4'b1110;
    cmd_valid = 1'b1;
    step("reset_drop");
    step("reset_drop");
    rst       = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("post_reset");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_data  = DW'($urandom);
      step("random");
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) step("random_tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
